// File: rtl/tmds_channel_decoder_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens and their ctrl encoding.
// The transmit-side encoder imports the same package.
package tmds_channel_decoder_pkg;

  localparam int unsigned SymW  = 10;
  localparam int unsigned CtrlW = 2;

  // Token constants, bit 9 leftmost.
  localparam logic [SymW-1:0] TokCtrl00 = 10'b1101010100;
  localparam logic [SymW-1:0] TokCtrl01 = 10'b0010101011;
  localparam logic [SymW-1:0] TokCtrl10 = 10'b0101010100;
  localparam logic [SymW-1:0] TokCtrl11 = 10'b1010101011;

  localparam logic [CtrlW-1:0] Ctrl00 = 2'b00;
  localparam logic [CtrlW-1:0] Ctrl01 = 2'b01;
  localparam logic [CtrlW-1:0] Ctrl10 = 2'b10;
  localparam logic [CtrlW-1:0] Ctrl11 = 2'b11;

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } align_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: control-token match plus 10b -> 8b data decode.
module tmds_symbol_decode
  import tmds_channel_decoder_pkg::*;
(
  input  logic [SymW-1:0]  aligned,
  output logic             is_token,
  output logic [CtrlW-1:0] ctrl,
  output logic [7:0]       data
);

  logic [7:0] d;

  always_comb begin
    is_token = 1'b1;
    ctrl     = Ctrl00;
    unique case (aligned)
      TokCtrl00: ctrl = Ctrl00;
      TokCtrl01: ctrl = Ctrl01;
      TokCtrl10: ctrl = Ctrl10;
      TokCtrl11: ctrl = Ctrl11;
      default:   is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d       = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = aligned[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: bit alignment from control tokens, then symbol decode.
// Optional lock-loss counter enabled by defining TMDS_ALIGN_STATS_EN.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned MISS_LIMIT = 4096,
  parameter int unsigned CNTW       = 13
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [SymW-1:0]  sym_in,
  output logic             locked,
  output logic [3:0]       align_offset,
  output logic             de,
  output logic [CtrlW-1:0] ctrl,
  output logic [7:0]       data
`ifdef TMDS_ALIGN_STATS_EN
  ,
  output logic [7:0]       relock_count
`endif
);

  align_state_e     state_q, state_d;
  logic [3:0]       offset_q, offset_d, offset_next;
  logic [CNTW-1:0]  miss_q, miss_d;
  logic [CNTW-1:0]  run_q, run_d;
  logic [SymW-1:0]  sym_prev_q;
  logic             de_q, de_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [7:0]       data_q, data_d;
  logic             lock_lost;

  logic [2*SymW-1:0] win;
  logic [SymW-1:0]   aligned;
  logic              is_token;
  logic [CtrlW-1:0]  tok_ctrl;
  logic [7:0]        dec_data;
  logic              miss_hit, run_hit;

  assign win = {sym_in, sym_prev_q};

  always_comb begin
    aligned = win[SymW-1:0];
    for (int k = 0; k < SymW; k++) begin
      if (offset_q == 4'(k)) aligned = win[k +: SymW];
    end
  end

  tmds_symbol_decode u_symbol_decode (
    .aligned  (aligned),
    .is_token (is_token),
    .ctrl     (tok_ctrl),
    .data     (dec_data)
  );

  assign miss_hit    = (miss_q == CNTW'(MISS_LIMIT - 1));
  assign run_hit     = (run_q == CNTW'(LOCK_COUNT - 1));
  assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  // A token always beats a miss-limit hit in the same cycle.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    miss_d    = miss_q;
    run_d     = run_q;
    lock_lost = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (is_token) begin
          state_d = StVerify;
          run_d   = CNTW'(1);
          miss_d  = '0;
        end else if (miss_hit) begin
          offset_d = offset_next;
          miss_d   = '0;
        end else begin
          miss_d = miss_q + CNTW'(1);
        end
      end
      StVerify: begin
        if (is_token) begin
          if (run_hit) begin
            state_d = StLocked;
            miss_d  = '0;
          end else begin
            run_d = run_q + CNTW'(1);
          end
        end else begin
          state_d = StSearch;
          miss_d  = '0;
        end
      end
      StLocked: begin
        if (is_token) begin
          miss_d = '0;
        end else if (miss_hit) begin
          state_d   = StSearch;
          offset_d  = offset_next;
          miss_d    = '0;
          lock_lost = 1'b1;
        end else begin
          miss_d = miss_q + CNTW'(1);
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Outputs follow the next state so locked and de change on the same edge.
  always_comb begin
    de_d   = 1'b0;
    ctrl_d = '0;
    data_d = '0;
    if (state_d == StLocked) begin
      if (is_token) begin
        ctrl_d = tok_ctrl;
      end else begin
        de_d   = 1'b1;
        ctrl_d = ctrl_q;
        data_d = dec_data;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q    <= StSearch;
      offset_q   <= '0;
      miss_q     <= '0;
      run_q      <= '0;
      sym_prev_q <= '0;
      de_q       <= 1'b0;
      ctrl_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      miss_q     <= miss_d;
      run_q      <= run_d;
      sym_prev_q <= sym_in;
      de_q       <= de_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
    end
  end

`ifdef TMDS_ALIGN_STATS_EN
  logic [7:0] relock_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      relock_q <= '0;
    end else if (lock_lost && relock_q != 8'hFF) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign relock_count = relock_q;
`endif

  assign locked       = (state_q == StLocked);
  assign align_offset = offset_q;
  assign de           = de_q;
  assign ctrl         = ctrl_q;
  assign data         = data_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: stimulus pushes timed expectations, a negedge
// monitor pops and compares them.
module tb_tmds_channel_decoder;

  localparam logic [9:0] Tok0 = 10'b1101010100;
  localparam logic [9:0] Tok1 = 10'b0010101011;
  localparam logic [9:0] Tok2 = 10'b0101010100;

  localparam int KLocked = 0;
  localparam int KOffset = 1;
  localparam int KDe     = 2;
  localparam int KCtrl   = 3;
  localparam int KData   = 4;
  localparam int KRelock = 5;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b1;
  logic [9:0] sym_in  = '0;
  logic       locked;
  logic [3:0] align_offset;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
`ifdef TMDS_ALIGN_STATS_EN
  logic [7:0] relock_count;
`endif

  tmds_channel_decoder dut (
    .clk_pix      (clk_pix),
    .rst_pix      (rst_pix),
    .sym_in       (sym_in),
    .locked       (locked),
    .align_offset (align_offset),
    .de           (de),
    .ctrl         (ctrl),
    .data         (data)
`ifdef TMDS_ALIGN_STATS_EN
    ,
    .relock_count (relock_count)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  typedef struct {int due; int kind; int val;} chk_t;
  typedef struct {int due; logic [7:0] val;} dat_t;
  chk_t chk_q[$];
  dat_t dat_q[$];
  int   errors = 0;
  int   checks = 0;

  int         shift   = 0;
  logic [9:0] carry   = '0;
  int         enc_cnt = 0;
  int         t_issue = 0;
  logic [7:0] bytes [4] = '{8'h00, 8'hFF, 8'h55, 8'hA5};

  function automatic string kind_name(input int kind);
    case (kind)
      KLocked: return "locked";
      KOffset: return "align_offset";
      KDe:     return "de";
      KCtrl:   return "ctrl";
      KData:   return "data";
      KRelock: return "relock_count";
      default: return "unknown";
    endcase
  endfunction

  function automatic int observe(input int kind);
    case (kind)
      KLocked: return int'(locked);
      KOffset: return int'(align_offset);
      KDe:     return int'(de);
      KCtrl:   return int'(ctrl);
      KData:   return int'(data);
`ifdef TMDS_ALIGN_STATS_EN
      KRelock: return int'(relock_count);
`endif
      default: return -1;
    endcase
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_chk(input int due, input int kind, input int val);
    chk_t c;
    c.due = due; c.kind = kind; c.val = val;
    chk_q.push_back(c);
  endtask

  task automatic push_dat(input int due, input logic [7:0] val);
    dat_t d;
    d.due = due; d.val = val;
    dat_q.push_back(d);
  endtask

  // Monitor: timed expectations plus the de-qualified data scoreboard.
  always @(negedge clk_pix) begin
    chk_t c;
    dat_t d;
    while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
      c = chk_q.pop_front();
      if (c.due < cyc) begin
        checks++; errors++;
        $display("FAIL stale_%s: due cycle %0d, now %0d", kind_name(c.kind), c.due, cyc);
      end else begin
        compare(kind_name(c.kind), observe(c.kind), c.val);
      end
    end
    if (de) begin
      if (dat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_de: data %0h at cycle %0d, none expected", data, cyc);
      end else begin
        d = dat_q.pop_front();
        compare("data", int'(data), int'(d.val));
        compare("data_latency", cyc, d.due);
      end
    end else if (dat_q.size() > 0 && dat_q[0].due < cyc) begin
      d = dat_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_data: expected %0h due cycle %0d, de low", d.val, d.due);
    end
  end

  // Serialise one symbol into the word stream at the current bit shift.
  task automatic send_sym(input logic [9:0] s);
    logic [19:0] w;
    @(posedge clk_pix);
    #1;
    w       = {10'b0, s} << shift;
    sym_in  = w[9:0] | carry;
    carry   = w[19:10];
    t_issue = cyc;
  endtask

  task automatic tmds_encode(input logic [7:0] b, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    logic use_xnor;
    n1d      = $countones(b);
    use_xnor = (n1d > 4) || (n1d == 4 && b[0] == 1'b0);
    qm[0]    = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~use_xnor;
    n1q   = $countones(qm[7:0]);
    n0q   = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + (n0q - n1q);
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(~qm[8]) + (n1q - n0q);
    end
  endtask

  // sym_in is held for two cycles first so pending token outputs land before reset.
  task automatic do_reset();
    repeat (2) @(posedge clk_pix);
    #1;
    rst_pix = 1'b1;
    sym_in  = '0;
    carry   = '0;
    repeat (2) @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;
  endtask

  task automatic push_reset_state(input int due);
    push_chk(due, KLocked, 0);
    push_chk(due, KOffset, 0);
    push_chk(due, KDe, 0);
    push_chk(due, KCtrl, 0);
    push_chk(due, KData, 0);
`ifdef TMDS_ALIGN_STATS_EN
    push_chk(due, KRelock, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] q;
    int e;

    // Reset state.
    do_reset();
    push_reset_state(cyc);

    // 1: 20 tokens at offset 0, lock after the 16th.
    for (int i = 0; i < 20; i++) begin
      send_sym(Tok0);
      push_chk(t_issue + 2, KLocked, (i >= 15) ? 1 : 0);
      if (i == 15 || i == 19) begin
        push_chk(t_issue + 2, KCtrl, 0);
        push_chk(t_issue + 2, KDe, 0);
        push_chk(t_issue + 2, KOffset, 0);
      end
    end

    // 4: VERIFY aborted by a data symbol, offset kept, then a fresh 16-token lock.
    do_reset();
    for (int i = 0; i < 10; i++) send_sym(Tok0);
    tmds_encode(8'h3C, q);
    send_sym(q);
    push_chk(t_issue + 2, KLocked, 0);
    push_chk(t_issue + 2, KOffset, 0);
    push_chk(t_issue + 2, KDe, 0);
    for (int i = 0; i < 16; i++) begin
      send_sym(Tok0);
      if (i >= 14) push_chk(t_issue + 2, KLocked, (i == 15) ? 1 : 0);
    end

    // 6: reset mid-active-line while locked.
    for (int i = 0; i < 8; i++) begin
      tmds_encode(bytes[i % 4], q);
      send_sym(q);
      if (i < 7) push_dat(t_issue + 2, bytes[i % 4]);
      if (i == 2) push_chk(t_issue + 2, KCtrl, 0);
    end
    @(posedge clk_pix);
    #1;
    rst_pix = 1'b1;
    sym_in  = '0;
    carry   = '0;
    push_reset_state(cyc + 1);
    @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;

    // 2: stream shifted by 3 bits; acquisition then one blanking/active/blanking line.
    shift   = 3;
    enc_cnt = 0;
    begin
      int n;
      n = 0;
      while (!locked && n < 20000) begin
        send_sym(Tok0);
        n++;
      end
    end
    compare("acquire_locked", int'(locked), 1);
    compare("acquire_offset", int'(align_offset), 3);
    for (int i = 0; i < 100; i++) begin
      send_sym(Tok1);
      if (i == 99) begin
        push_chk(t_issue + 2, KCtrl, 1);
        push_chk(t_issue + 2, KDe, 0);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      tmds_encode(bytes[i % 4], q);
      send_sym(q);
      push_dat(t_issue + 2, bytes[i % 4]);
      if (i == 500) begin
        push_chk(t_issue + 2, KCtrl, 1);
        push_chk(t_issue + 2, KOffset, 3);
      end
    end
    for (int i = 0; i < 100; i++) begin
      send_sym(Tok2);
      if (i == 99) begin
        push_chk(t_issue + 2, KCtrl, 2);
        push_chk(t_issue + 2, KDe, 0);
      end
    end

    // 3: 4096 data symbols with no token drop the lock and advance the offset.
    for (int j = 1; j <= 4096; j++) begin
      tmds_encode(bytes[j % 4], q);
      send_sym(q);
      if (j < 4096) push_dat(t_issue + 2, bytes[j % 4]);
      if (j == 4095) begin
        push_chk(t_issue + 2, KLocked, 1);
        push_chk(t_issue + 2, KOffset, 3);
      end
      if (j == 4096) begin
        push_chk(t_issue + 2, KLocked, 0);
        push_chk(t_issue + 2, KOffset, 4);
        push_chk(t_issue + 2, KDe, 0);
`ifdef TMDS_ALIGN_STATS_EN
        push_chk(t_issue + 2, KRelock, 1);
`endif
      end
    end

    // 5: no tokens; offset steps every MISS_LIMIT cycles and wraps 9 -> 0.
    e = t_issue;
    push_chk(e + 2 + 4096 - 1, KOffset, 4);
    push_chk(e + 2 + 4096, KOffset, 5);
    push_chk(e + 2 + 4096 * 5, KOffset, 9);
    push_chk(e + 2 + 4096 * 6 - 1, KOffset, 9);
    push_chk(e + 2 + 4096 * 6, KOffset, 0);
    push_chk(e + 2 + 4096 * 6, KLocked, 0);
    for (int i = 0; i < 24600; i++) send_sym(10'h000);

    repeat (3) @(posedge clk_pix);
    #1;
    if (chk_q.size() > 0 || dat_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL leftover: %0d timed and %0d data expectations never checked",
               chk_q.size(), dat_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
